shift_operand_unit: RTL and testbench

- Pipelined, handshaked operand-2 generator for the ARM execute stage.
- Produces Val2 and the shifter carry-out from one of three sources:
  - immediate rotate;
  - register shifted by an immediate amount;
  - register shifted by a register amount (Rs[7:0]).
- Memory-offset pass-through mode.
- Full ARM special-case encodings (RRX, LSR/ASR #0 = full width, amount >= width).
- Sits between the ID/EX register and the ALU; supports stall (out_ready low) and flush.

---
 rtl/shifter_pkg.sv | 30 +++
 rtl/barrel_shift_core.sv | 93 +++++++++
 rtl/shift_operand_unit.sv | 203 ++++++++++++++++++++
 tb/tb_shift_operand_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types and constants for the ARM operand-2 shifter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package shifter_pkg;

  // Shift type as encoded in instruction bits [6:5]
  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_type_e;

  // Width of the immediate rotate field (bits [11:8]); rotation is twice this value
  localparam int IMM_ROT_W = 4;

  // Effective shift amount width: holds 0..255 from Rs, saturated to DATA_W+1
  localparam int AMT_W = 9;

  // Ceiling log2 for sizing amount/index fields
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational ARM barrel shifter: LSL/LSR/ASR/ROR/RRX with carry-out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage registers decide when results are captured.
module barrel_shift_core
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  shift_type_e             shift_type_i,
  input  logic [AMT_W-1:0]        amt_i,
  input  logic                    rrx_i,
  input  logic [DATA_W-1:0]       operand_i,
  input  logic                    carry_i,
  output logic [DATA_W-1:0]       result_o,
  output logic                    carry_o
);

  localparam int                SW       = clog2(DATA_W);
  localparam logic [AMT_W-1:0]  AMT_FULL = AMT_W'(DATA_W);
  localparam logic [SW-1:0]     SH_ONE   = SW'(1);

  logic [SW-1:0] sh;
  logic [SW-1:0] sh_m1;
  logic [SW-1:0] sh_neg;
  logic          in_range;
  logic          at_full;
  logic          is_zero;

  // For 0 < amt < W the low bits are the shift distance; W-amt wraps to -amt mod W
  assign sh       = amt_i[SW-1:0];
  assign sh_m1    = sh - SH_ONE;
  assign sh_neg   = SW'(0) - sh;
  assign in_range = (amt_i < AMT_FULL);
  assign at_full  = (amt_i == AMT_FULL);
  assign is_zero  = (amt_i == '0);

  // Shift datapath; a zero amount passes the operand and incoming carry untouched
  always_comb begin
    result_o = operand_i;
    carry_o  = carry_i;
    if (rrx_i) begin
      result_o = {carry_i, operand_i[DATA_W-1:1]};
      carry_o  = operand_i[0];
    end else if (!is_zero) begin
      case (shift_type_i)
        SH_LSL: begin
          if (in_range) begin
            result_o = operand_i << sh;
            carry_o  = operand_i[sh_neg];
          end else if (at_full) begin
            result_o = '0;
            carry_o  = operand_i[0];
          end else begin
            result_o = '0;
            carry_o  = 1'b0;
          end
        end
        SH_LSR: begin
          if (in_range) begin
            result_o = operand_i >> sh;
            carry_o  = operand_i[sh_m1];
          end else if (at_full) begin
            result_o = '0;
            carry_o  = operand_i[DATA_W-1];
          end else begin
            result_o = '0;
            carry_o  = 1'b0;
          end
        end
        SH_ASR: begin
          if (in_range) begin
            result_o = $unsigned($signed(operand_i) >>> sh);
            carry_o  = operand_i[sh_m1];
          end else begin
            result_o = {DATA_W{operand_i[DATA_W-1]}};
            carry_o  = operand_i[DATA_W-1];
          end
        end
        SH_ROR: begin
          // Decode folds amt mod W == 0 (amt != 0) onto amt == W
          if (in_range) begin
            result_o = (operand_i >> sh) | (operand_i << sh_neg);
            carry_o  = operand_i[sh_m1];
          end else begin
            result_o = operand_i;
            carry_o  = operand_i[DATA_W-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_operand_unit.sv
// ARM execute-stage operand-2 generator (immediate rotate, imm/reg shifts, memory offset).
// Latency: PIPE_STAGES cycles (1 = decode+shift in one register, 2 = decode reg then shift reg).
// Backpressure: valid/ready; stages advance when their successor is empty or draining; flush drops all.
module shift_operand_unit
  import shifter_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_mode,
  input  logic              imm,
  input  logic              reg_shift,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam int               SW       = clog2(DATA_W);
  localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(DATA_W);
  localparam logic [AMT_W-1:0] AMT_SAT  = AMT_W'(DATA_W + 1);

  // Decoded request (next state of the decode register when PIPE_STAGES == 2)
  shift_type_e        dec_type_d;
  logic [AMT_W-1:0]   dec_amt_d;
  logic               dec_rrx_d;
  logic               dec_mem_d;
  logic [DATA_W-1:0]  dec_opnd_d;

  logic [4:0]         imm_amt;
  logic [SW-1:0]      rs_mod;

  assign imm_amt = shift_operand[11:7];
  assign rs_mod  = val_rs[SW-1:0];

  // Resolve mode priority and ARM special encodings into type/amount/rrx
  always_comb begin
    dec_type_d = shift_type_e'(shift_operand[6:5]);
    dec_amt_d  = '0;
    dec_rrx_d  = 1'b0;
    dec_mem_d  = 1'b0;
    dec_opnd_d = val_rm;
    if (mem_mode) begin
      // Zero amount makes the core pass the offset and C flag through
      dec_mem_d  = 1'b1;
      dec_type_d = SH_LSL;
      dec_opnd_d = DATA_W'(shift_operand);
    end else if (imm) begin
      // Rotate by 2*rot; the ROR rule gives C = result MSB, or carry_in when rot == 0
      dec_type_d = SH_ROR;
      dec_opnd_d = DATA_W'(shift_operand[7:0]);
      dec_amt_d  = AMT_W'({shift_operand[8+IMM_ROT_W-1:8], 1'b0});
    end else if (!reg_shift) begin
      if (imm_amt == 5'd0) begin
        case (dec_type_d)
          SH_LSR, SH_ASR: dec_amt_d = AMT_FULL;
          SH_ROR:         dec_rrx_d = 1'b1;
          default:        dec_amt_d = '0;
        endcase
      end else begin
        dec_amt_d = AMT_W'(imm_amt);
      end
    end else if (dec_type_d == SH_ROR) begin
      // Register rotate reduces mod W; a non-zero multiple of W maps to W
      if (val_rs == 8'd0) begin
        dec_amt_d = '0;
      end else if (rs_mod == '0) begin
        dec_amt_d = AMT_FULL;
      end else begin
        dec_amt_d = AMT_W'(rs_mod);
      end
    end else if (AMT_W'(val_rs) > AMT_FULL) begin
      // Every amount beyond W behaves identically, so clamp to W+1
      dec_amt_d = AMT_SAT;
    end else begin
      dec_amt_d = AMT_W'(val_rs);
    end
  end

  // Inputs to the shift stage, sourced from decode directly or from the decode register
  shift_type_e        core_type;
  logic [AMT_W-1:0]   core_amt;
  logic               core_rrx;
  logic               core_mem;
  logic [DATA_W-1:0]  core_opnd;
  logic               core_cin;
  logic               feed_vld;

  logic               out_vld_q;
  logic [DATA_W-1:0]  val2_q;
  logic               carry_q;
  logic               out_adv;

  assign out_adv = !out_vld_q || out_ready;

  generate
    if (PIPE_STAGES == 2) begin : g_two
      logic               s0_vld_q;
      shift_type_e        s0_type_q;
      logic [AMT_W-1:0]   s0_amt_q;
      logic               s0_rrx_q;
      logic               s0_mem_q;
      logic [DATA_W-1:0]  s0_opnd_q;
      logic               s0_cin_q;

      assign in_ready = !s0_vld_q || out_adv;

      // Decode register: loads on accept, holds while the shift stage is blocked
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s0_vld_q  <= 1'b0;
          s0_type_q <= SH_LSL;
          s0_amt_q  <= '0;
          s0_rrx_q  <= 1'b0;
          s0_mem_q  <= 1'b0;
          s0_opnd_q <= '0;
          s0_cin_q  <= 1'b0;
        end else if (flush) begin
          s0_vld_q <= 1'b0;
        end else if (in_ready) begin
          s0_vld_q <= in_valid;
          if (in_valid) begin
            s0_type_q <= dec_type_d;
            s0_amt_q  <= dec_amt_d;
            s0_rrx_q  <= dec_rrx_d;
            s0_mem_q  <= dec_mem_d;
            s0_opnd_q <= dec_opnd_d;
            s0_cin_q  <= carry_in;
          end
        end
      end

      assign core_type = s0_type_q;
      assign core_amt  = s0_amt_q;
      assign core_rrx  = s0_rrx_q;
      assign core_mem  = s0_mem_q;
      assign core_opnd = s0_opnd_q;
      assign core_cin  = s0_cin_q;
      assign feed_vld  = s0_vld_q;
    end else begin : g_one
      assign in_ready  = out_adv;
      assign core_type = dec_type_d;
      assign core_amt  = dec_amt_d;
      assign core_rrx  = dec_rrx_d;
      assign core_mem  = dec_mem_d;
      assign core_opnd = dec_opnd_d;
      assign core_cin  = carry_in;
      assign feed_vld  = in_valid;
    end
  endgenerate

  logic [DATA_W-1:0] core_res;
  logic              core_c;
  logic [DATA_W-1:0] shift_res;
  logic              shift_c;

  barrel_shift_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .shift_type_i (core_type),
    .amt_i        (core_amt),
    .rrx_i        (core_rrx),
    .operand_i    (core_opnd),
    .carry_i      (core_cin),
    .result_o     (core_res),
    .carry_o      (core_c)
  );

  // Memory offsets bypass the shifter entirely
  assign shift_res = core_mem ? core_opnd : core_res;
  assign shift_c   = core_mem ? core_cin  : core_c;

  // Output register: captures only on a real transfer so data holds during a stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld_q <= 1'b0;
      val2_q    <= '0;
      carry_q   <= 1'b0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
    end else if (out_adv) begin
      out_vld_q <= feed_vld;
      if (feed_vld) begin
        val2_q  <= shift_res;
        carry_q <= shift_c;
      end
    end
  end

  assign out_valid = out_vld_q;
  assign val2      = val2_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_operand_unit.sv
module tb_shift_operand_unit;

  localparam int DW = 32;
  localparam int PS = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          mem_mode;
  logic          imm;
  logic          reg_shift;
  logic [11:0]   shift_operand;
  logic [DW-1:0] val_rm;
  logic [7:0]    val_rs;
  logic          carry_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] val2;
  logic          carry_out;

  shift_operand_unit #(.DATA_W(DW), .PIPE_STAGES(PS)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .mem_mode      (mem_mode),
    .imm           (imm),
    .reg_shift     (reg_shift),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .val_rs        (val_rs),
    .carry_in      (carry_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .val2          (val2),
    .carry_out     (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_in = 0;
  int n_out = 0;
  int n_block = 0;

  typedef struct {
    logic [DW-1:0] v;
    logic          c;
    bit            has_k;
    logic [DW-1:0] kv;
    logic          kc;
  } exp_t;

  exp_t sb[$];

  bit            k_has = 0;
  logic [DW-1:0] k_v = '0;
  logic          k_c = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Rotate right by r using bit arithmetic
  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x, input int r);
    logic [DW-1:0] y;
    for (int i = 0; i < DW; i++) y[i] = x[(i + r) % DW];
    return y;
  endfunction

  // Reference: {carry, val2} straight from the ARM operand-2 rules
  function automatic logic [DW:0] model(input logic m, input logic im, input logic rf,
                                        input logic [11:0] so, input logic [DW-1:0] rm,
                                        input logic [7:0] rs, input logic cin);
    int amt, rot, typ, r;
    logic [DW-1:0] v, t;
    logic c;
    if (m) return {cin, DW'(so)};
    if (im) begin
      rot = 2 * int'(so[11:8]);
      v = rotr(DW'(so[7:0]), rot);
      c = (rot == 0) ? cin : v[DW-1];
      return {c, v};
    end
    typ = int'(so[6:5]);
    if (!rf) begin
      amt = int'(so[11:7]);
      if (amt == 0) begin
        if (typ == 0) return {cin, rm};
        if (typ == 3) return {rm[0], cin, rm[DW-1:1]};
        amt = DW;
      end
    end else begin
      amt = int'(rs);
    end
    if (amt == 0) return {cin, rm};
    v = '0;
    c = 1'b0;
    case (typ)
      0: begin
        if (amt < DW) begin
          v = rm << amt;
          t = rm << (amt - 1);
          c = t[DW-1];
        end else if (amt == DW) begin
          c = rm[0];
        end
      end
      1: begin
        if (amt <= DW) begin
          v = (amt == DW) ? '0 : (rm >> amt);
          t = rm >> (amt - 1);
          c = t[0];
        end
      end
      2: begin
        if (amt >= DW) begin
          v = {DW{rm[DW-1]}};
          c = rm[DW-1];
        end else begin
          for (int i = 0; i < DW; i++) v[i] = (i + amt < DW) ? rm[i + amt] : rm[DW-1];
          c = rm[amt - 1];
        end
      end
      default: begin
        r = amt % DW;
        if (r == 0) begin
          v = rm;
          c = rm[DW-1];
        end else begin
          v = rotr(rm, r);
          c = rm[r - 1];
        end
      end
    endcase
    return {c, v};
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  bit            stall_q = 0;
  logic [DW-1:0] held_v = '0;
  logic          held_c = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic [DW:0] r;
    if (!rst || flush) begin
      sb.delete();
      stall_q = 0;
    end else begin
      if (stall_q && out_valid) begin
        chk("hold_val2", val2, held_v);
        chk("hold_carry", carry_out, held_c);
      end
      if (in_valid && !in_ready) n_block++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("val2", val2, e.v);
          chk("carry", carry_out, e.c);
          if (e.has_k) begin
            chk("k_val2", val2, e.kv);
            chk("k_carry", carry_out, e.kc);
          end
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        r = model(mem_mode, imm, reg_shift, shift_operand, val_rm, val_rs, carry_in);
        e.v = r[DW-1:0];
        e.c = r[DW];
        e.has_k = k_has;
        e.kv = k_v;
        e.kc = k_c;
        sb.push_back(e);
        n_in++;
      end
      stall_q = out_valid && !out_ready;
      held_v = val2;
      held_c = carry_out;
    end
  end

  task automatic push_req(input logic m, input logic im, input logic rf, input logic [11:0] so,
                          input logic [DW-1:0] rm, input logic [7:0] rs, input logic cin);
    int guard;
    bit acc;
    mem_mode = m; imm = im; reg_shift = rf; shift_operand = so;
    val_rm = rm; val_rs = rs; carry_in = cin; in_valid = 1'b1;
    guard = 0;
    acc = 0;
    while (!acc && guard < 64) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic dir(input logic m, input logic im, input logic rf, input logic [11:0] so,
                     input logic [DW-1:0] rm, input logic [7:0] rs, input logic cin,
                     input logic [DW-1:0] kv, input logic kc);
    k_has = 1; k_v = kv; k_c = kc;
    push_req(m, im, rf, so, rm, rs, cin);
    k_has = 0;
  endtask

  task automatic drain(input string tag);
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    chk({tag, "_empty"}, sb.size(), 0);
    chk({tag, "_count"}, n_out, n_in);
  endtask

  task automatic rand_req();
    logic [DW-1:0] rm;
    logic [7:0]    rs;
    int sel;
    sel = int'($urandom_range(0, 3));
    rm = (sel == 0) ? 32'h8000_0001 : (sel == 1) ? 32'h7FFF_FFFE : DW'($urandom);
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: rs = 8'($urandom_range(0, 255));
      1: rs = 8'($urandom_range(29, 35));
      2: rs = ($urandom_range(0, 1) == 0) ? 8'd64 : 8'd96;
      default: rs = 8'($urandom_range(0, 8));
    endcase
    push_req(($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), 1'($urandom),
             12'($urandom), rm, rs, 1'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, nb0;
    bit done;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; mem_mode = 1'b0; imm = 1'b1; reg_shift = 1'b0;
    shift_operand = 12'h4FF; val_rm = '0; val_rs = '0; carry_in = 1'b0;

    // Reset held with a pending request
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_val2", val2, 0);
      chk("rst_carry", carry_out, 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // First accept after release, and its latency
    dir(0, 1, 0, 12'h4FF, '0, 8'd0, 0, 32'hFF00_0000, 1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 10);
    chk("latency", cnt, PS);
    @(posedge clk); #1;

    // Directed encodings
    dir(0, 1, 0, 12'h0FF, '0,           8'd0,  1, 32'h0000_00FF, 1);
    dir(0, 0, 0, 12'h020, 32'h8000_0001, 8'd0,  1, 32'h0000_0000, 1);
    dir(0, 0, 0, 12'h040, 32'h8000_0001, 8'd0,  1, 32'hFFFF_FFFF, 1);
    dir(0, 0, 0, 12'h060, 32'h8000_0001, 8'd0,  1, 32'hC000_0000, 1);
    dir(0, 0, 1, 12'h010, 32'h8000_0001, 8'd32, 1, 32'h0000_0000, 1);
    dir(0, 0, 1, 12'h010, 32'h8000_0001, 8'd33, 1, 32'h0000_0000, 0);
    dir(0, 0, 1, 12'h070, 32'h8000_0001, 8'd64, 0, 32'h8000_0001, 1);
    dir(0, 0, 1, 12'h030, 32'h8000_0001, 8'd0,  0, 32'h8000_0001, 0);
    dir(1, 1, 1, 12'hABC, 32'h8000_0001, 8'd7,  1, 32'h0000_0ABC, 1);
    dir(0, 0, 0, 12'h000, 32'h8000_0001, 8'd0,  0, 32'h8000_0001, 0);
    dir(0, 0, 0, 12'h200, 32'h8000_0001, 8'd0,  1, 32'h0000_0010, 0);
    dir(0, 0, 1, 12'h050, 32'h8000_0001, 8'd40, 0, 32'hFFFF_FFFF, 1);
    drain("directed");

    // Back-to-back stream with a 3-cycle consumer stall
    n_in = 0; n_out = 0; nb0 = n_block;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push_req(0, 0, 1, 12'($urandom), DW'($urandom), 8'($urandom_range(0, 40)), 1'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream");
    chk("in_ready_fell", (n_block > nb0), 1);

    // Reset in the middle of operation
    out_ready = 1'b0;
    push_req(0, 1, 0, 12'h3A5, '0, 8'd0, 0);
    push_req(0, 0, 1, 12'h010, 32'h1234_5678, 8'd4, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_val2", val2, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_idle", out_valid, 0);
    end
    @(posedge clk); #1;

    // Flush with two entries in flight and a simultaneous request
    out_ready = 1'b0;
    push_req(0, 1, 0, 12'h1FF, '0, 8'd0, 0);
    push_req(0, 0, 1, 12'h030, 32'hDEAD_BEEF, 8'd8, 1);
    chk("flush_pre_valid", out_valid, 1);
    mem_mode = 1'b1; shift_operand = 12'h777; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Randomized traffic with random consumer backpressure
    n_in = 0; n_out = 0;
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          rand_req();
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
